// File: rtl/tpu_pkg.sv
// Shared types and helpers for the GEMM tile scheduler and control_unit.
package tpu_pkg;

    localparam int TILE       = 16;
    localparam int TILE_SHIFT = 4;
    localparam int CMD_ADDR_W = 10;
    localparam int LEN_W      = 8;
    localparam int DIM_W      = 8;
    localparam int DIM_CW     = DIM_W + 1;

    // Command word consumed by control_unit; len_m occupies bits [7:0].
    typedef struct packed {
        logic [CMD_ADDR_W-1:0] addr_d;
        logic [CMD_ADDR_W-1:0] addr_c;
        logic [CMD_ADDR_W-1:0] addr_b;
        logic [CMD_ADDR_W-1:0] addr_a;
        logic [LEN_W-1:0]      len_n;
        logic [LEN_W-1:0]      len_k;
        logic [LEN_W-1:0]      len_m;
    } command_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ISSUE,
        ST_BARRIER,
        ST_DRAIN,
        ST_DONE
    } sched_state_t;

    // Number of 16-element tiles covering a dimension (ceiling divide).
    function automatic logic [DIM_W:0] tile_count(input logic [DIM_W-1:0] dim);
        logic [DIM_W:0] sum;
        sum = {1'b0, dim} + DIM_CW'(TILE - 1);
        return sum >> TILE_SHIFT;
    endfunction

    // Length of tile idx along a dimension: a full tile, or the ragged remainder.
    function automatic logic [LEN_W-1:0] tile_len(input logic [DIM_W-1:0] dim,
                                                  input logic [DIM_W-1:0] idx);
        logic [DIM_W:0] rem;
        rem = {1'b0, dim} - ({1'b0, idx} << TILE_SHIFT);
        if (rem > DIM_CW'(TILE))
            return LEN_W'(TILE);
        return rem[LEN_W-1:0];
    endfunction

endpackage

// File: rtl/tile_index_walker.sv
// Walks the (ki, mi, ni) tile space with ni innermost and ki outermost, keeping
// running word offsets for the A, B and D tile arrays so that no multiplier is needed.
module tile_index_walker #(
    parameter int ADDR_WIDTH = 10,
    parameter int DIM_WIDTH  = 8,
    parameter int TILE       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  step,
    input  logic [DIM_WIDTH:0]    mt,
    input  logic [DIM_WIDTH:0]    kt,
    input  logic [DIM_WIDTH:0]    nt,
    output logic [DIM_WIDTH-1:0]  mi,
    output logic [DIM_WIDTH-1:0]  ki,
    output logic [DIM_WIDTH-1:0]  ni,
    output logic [ADDR_WIDTH-1:0] off_a,
    output logic [ADDR_WIDTH-1:0] off_b,
    output logic [ADDR_WIDTH-1:0] off_d,
    output logic                  pass_end,
    output logic                  last_tile
);

    localparam int                  SHIFT = $clog2(TILE);
    localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(TILE);

    // a_col_base = 16*ki, b_row_base = 16*ki*NT: restart points for a new mi row
    logic [ADDR_WIDTH-1:0] a_col_base;
    logic [ADDR_WIDTH-1:0] b_row_base;
    logic [ADDR_WIDTH-1:0] kt_stride;
    logic                  ni_last;
    logic                  mi_last;
    logic                  ki_last;

    assign kt_stride = ADDR_WIDTH'(kt) << SHIFT;
    assign ni_last   = ({1'b0, ni} == nt - 1'b1);
    assign mi_last   = ({1'b0, mi} == mt - 1'b1);
    assign ki_last   = ({1'b0, ki} == kt - 1'b1);
    assign pass_end  = ni_last && mi_last;
    assign last_tile = pass_end && ki_last;

    // Advance indices and offsets by one tile; the final tile wraps everything to zero.
    always_ff @(posedge clk) begin
        if (rst || clear || (step && last_tile)) begin
            mi         <= '0;
            ki         <= '0;
            ni         <= '0;
            off_a      <= '0;
            off_b      <= '0;
            off_d      <= '0;
            a_col_base <= '0;
            b_row_base <= '0;
        end else if (step) begin
            if (!ni_last) begin
                ni    <= ni + 1'b1;
                off_b <= off_b + STEP;
                off_d <= off_d + STEP;
            end else if (!mi_last) begin
                ni    <= '0;
                mi    <= mi + 1'b1;
                off_a <= off_a + kt_stride;
                off_b <= b_row_base;
                off_d <= off_d + STEP;
            end else begin
                ni         <= '0;
                mi         <= '0;
                ki         <= ki + 1'b1;
                a_col_base <= a_col_base + STEP;
                off_a      <= a_col_base + STEP;
                off_b      <= off_b + STEP;
                b_row_base <= off_b + STEP;
                off_d      <= '0;
            end
        end
    end

endmodule

// File: rtl/gemm_tile_scheduler.sv
// Splits one host GEMM job into 16x16x16 tile commands for control_unit and
// tracks their completion. Partial D of one K pass becomes C of the next, so a
// barrier waits for every tile of a pass to finish before the next pass issues.
//
//  state   | meaning
//  IDLE    | waiting for a job descriptor
//  SETUP   | compute tile counts, reset walker
//  ISSUE   | present tile commands while the outstanding window allows
//  BARRIER | end of a K pass; wait until all tiles of the pass are done
//  DRAIN   | all tiles issued; wait for the last completions
//  DONE    | one-cycle job_done pulse
module gemm_tile_scheduler
    import tpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int TILE       = 16,
    parameter int DIM_WIDTH  = 8,
    parameter int MAX_OUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [ADDR_WIDTH-1:0] job_base_a,
    input  logic [ADDR_WIDTH-1:0] job_base_b,
    input  logic [ADDR_WIDTH-1:0] job_base_c,
    input  logic [ADDR_WIDTH-1:0] job_base_d,
    input  logic [DIM_WIDTH-1:0]  job_m,
    input  logic [DIM_WIDTH-1:0]  job_k,
    input  logic [DIM_WIDTH-1:0]  job_n,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [63:0]           cmd_data,
    input  logic                  tile_done,
    output logic                  job_busy,
    output logic                  job_done,
    output logic                  job_err
);

    localparam int               OUT_W   = $clog2(MAX_OUT + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUT);

    sched_state_t          state;
    sched_state_t          state_next;

    logic [ADDR_WIDTH-1:0] base_a, base_b, base_c, base_d;
    logic [DIM_WIDTH-1:0]  dim_m, dim_k, dim_n;
    logic [DIM_WIDTH:0]    mt, kt, nt;

    logic [OUT_W-1:0]      outstanding;
    logic [OUT_W-1:0]      out_next;
    logic                  hs;
    logic                  done_eff;

    command_t              cmd_q;
    command_t              cmd_next;
    logic                  cmd_last_q;
    logic                  cmd_pass_end_q;

    logic                  accept;
    logic                  reject;
    logic                  load;
    logic                  walker_clear;

    logic [DIM_WIDTH-1:0]  mi, ki, ni;
    logic [ADDR_WIDTH-1:0] off_a, off_b, off_d;
    logic                  pass_end;
    logic                  last_tile;

    assign hs       = cmd_valid && cmd_ready;
    assign done_eff = tile_done && (outstanding != '0);
    assign cmd_data = cmd_q;

    tile_index_walker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DIM_WIDTH  (DIM_WIDTH),
        .TILE       (TILE)
    ) u_walker (
        .clk       (clk),
        .rst       (rst),
        .clear     (walker_clear),
        .step      (load),
        .mt        (mt),
        .kt        (kt),
        .nt        (nt),
        .mi        (mi),
        .ki        (ki),
        .ni        (ni),
        .off_a     (off_a),
        .off_b     (off_b),
        .off_d     (off_d),
        .pass_end  (pass_end),
        .last_tile (last_tile)
    );

    // Outstanding count after this cycle; a spurious tile_done at zero is dropped.
    always_comb begin
        out_next = outstanding;
        if (hs && !done_eff)
            out_next = outstanding + 1'b1;
        else if (!hs && done_eff)
            out_next = outstanding - 1'b1;
    end

    // Command for the tile the walker currently points at; later K passes read partial D as C.
    always_comb begin
        cmd_next        = '0;
        cmd_next.len_m  = tile_len(dim_m, mi);
        cmd_next.len_k  = tile_len(dim_k, ki);
        cmd_next.len_n  = tile_len(dim_n, ni);
        cmd_next.addr_a = base_a + off_a;
        cmd_next.addr_b = base_b + off_b;
        cmd_next.addr_d = base_d + off_d;
        cmd_next.addr_c = (ki == '0) ? (base_c + off_d) : (base_d + off_d);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next state, status outputs and issue decision.
    always_comb begin
        state_next   = state;
        job_ready    = 1'b0;
        job_busy     = 1'b0;
        job_done     = 1'b0;
        accept       = 1'b0;
        reject       = 1'b0;
        load         = 1'b0;
        walker_clear = 1'b0;
        case (state)
            ST_IDLE: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    if (job_m == '0 || job_k == '0 || job_n == '0) begin
                        reject = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                job_busy     = 1'b1;
                walker_clear = 1'b1;
                state_next   = ST_ISSUE;
            end
            ST_ISSUE: begin
                job_busy = 1'b1;
                if (hs && cmd_last_q)
                    state_next = ST_DRAIN;
                else if (hs && cmd_pass_end_q)
                    state_next = ST_BARRIER;
                else if ((!cmd_valid || hs) && (out_next < OUT_MAX))
                    load = 1'b1;
            end
            ST_BARRIER: begin
                job_busy = 1'b1;
                if (outstanding == '0)
                    state_next = ST_ISSUE;
            end
            ST_DRAIN: begin
                job_busy = 1'b1;
                if (outstanding == '0)
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                job_done   = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Descriptor capture on accept, tile counts derived once in SETUP.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_a <= '0;
            base_b <= '0;
            base_c <= '0;
            base_d <= '0;
            dim_m  <= '0;
            dim_k  <= '0;
            dim_n  <= '0;
            mt     <= '0;
            kt     <= '0;
            nt     <= '0;
        end else begin
            if (accept) begin
                base_a <= job_base_a;
                base_b <= job_base_b;
                base_c <= job_base_c;
                base_d <= job_base_d;
                dim_m  <= job_m;
                dim_k  <= job_k;
                dim_n  <= job_n;
            end
            if (state == ST_SETUP) begin
                mt <= tile_count(dim_m);
                kt <= tile_count(dim_k);
                nt <= tile_count(dim_n);
            end
        end
    end

    // Registered command port: held stable until the handshake, reloaded in the same cycle for back-to-back issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid      <= 1'b0;
            cmd_q          <= '0;
            cmd_last_q     <= 1'b0;
            cmd_pass_end_q <= 1'b0;
        end else if (load) begin
            cmd_valid      <= 1'b1;
            cmd_q          <= cmd_next;
            cmd_last_q     <= last_tile;
            cmd_pass_end_q <= pass_end;
        end else if (hs) begin
            cmd_valid <= 1'b0;
        end
    end

    // Outstanding tile counter and the reject pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            job_err     <= 1'b0;
        end else begin
            outstanding <= out_next;
            job_err     <= reject;
        end
    end

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Randomized bench for gemm_tile_scheduler against a loop-nest reference model.
module tb_gemm_tile_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [9:0]  job_base_a, job_base_b, job_base_c, job_base_d;
    logic [7:0]  job_m, job_k, job_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [63:0] cmd_data;
    logic        tile_done;
    logic        job_busy;
    logic        job_done;
    logic        job_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_q[$];
    bit          pe_q[$];

    always #5 clk = ~clk;

    gemm_tile_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_base_a (job_base_a),
        .job_base_b (job_base_b),
        .job_base_c (job_base_c),
        .job_base_d (job_base_d),
        .job_m      (job_m),
        .job_k      (job_k),
        .job_n      (job_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .tile_done  (tile_done),
        .job_busy   (job_busy),
        .job_done   (job_done),
        .job_err    (job_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int tlen(input int dim, input int idx);
        int r;
        r = dim - 16 * idx;
        return (r > 16) ? 16 : r;
    endfunction

    // Expected command stream straight from the tiling rules.
    task automatic build_expected(input int m, input int k, input int n,
                                  input int ba, input int bb, input int bc, input int bd);
        int mt, kt, nt, aa, ab, ac, ad, lm, lk, ln;
        logic [63:0] w;
        exp_q.delete();
        pe_q.delete();
        mt = (m + 15) / 16;
        kt = (k + 15) / 16;
        nt = (n + 15) / 16;
        for (int ki = 0; ki < kt; ki++)
            for (int mi = 0; mi < mt; mi++)
                for (int ni = 0; ni < nt; ni++) begin
                    aa = (ba + 16 * (mi * kt + ki)) % 1024;
                    ab = (bb + 16 * (ki * nt + ni)) % 1024;
                    ad = (bd + 16 * (mi * nt + ni)) % 1024;
                    ac = (ki == 0) ? (bc + 16 * (mi * nt + ni)) % 1024 : ad;
                    lm = tlen(m, mi);
                    lk = tlen(k, ki);
                    ln = tlen(n, ni);
                    w  = {ad[9:0], ac[9:0], ab[9:0], aa[9:0], ln[7:0], lk[7:0], lm[7:0]};
                    exp_q.push_back(w);
                    pe_q.push_back((mi == mt - 1) && (ni == nt - 1) && (ki != kt - 1));
                end
    endtask

    // One whole job with random ready/done; optional 10-cycle ready stall and delayed completions.
    task automatic run_job(input int m, input int k, input int n,
                           input int ba, input int bb, input int bc, input int bd,
                           input int stall_from, input int done_from,
                           output logic [63:0] first_cmd, output int max_seen);
        int cyc, out_model, hold_viol, barrier_viol, outmax_viol, extra, first_lat, idx;
        bit bar_pend, prev_wait, done_seen, got_first, rdy, dn, p;
        logic [63:0] prev_data, e;
        build_expected(m, k, n, ba, bb, bc, bd);
        cyc = 0; out_model = 0; hold_viol = 0; barrier_viol = 0; outmax_viol = 0;
        extra = 0; first_lat = -1; idx = 0; max_seen = 0;
        bar_pend = 0; prev_wait = 0; done_seen = 0; got_first = 0;
        prev_data = '0; first_cmd = '0;
        chk("job_ready_idle", 64'(job_ready), 64'(1));
        job_base_a = ba[9:0]; job_base_b = bb[9:0]; job_base_c = bc[9:0]; job_base_d = bd[9:0];
        job_m = m[7:0]; job_k = k[7:0]; job_n = n[7:0];
        job_valid = 1'b1;
        @(posedge clk); #1;
        job_valid = 1'b0;
        chk("busy_after_accept", 64'(job_busy), 64'(1));
        chk("ready_low_busy", 64'(job_ready), 64'(0));
        while (cyc < 4000 && !done_seen) begin
            if (job_done) begin
                done_seen = 1;
            end else begin
                if (cmd_valid && first_lat < 0) first_lat = cyc;
                if (prev_wait && (!cmd_valid || cmd_data !== prev_data)) hold_viol++;
                if (bar_pend && cmd_valid) barrier_viol++;
                if (bar_pend && out_model == 0) bar_pend = 0;
                if (cmd_valid && out_model >= 4) outmax_viol++;
                rdy = (cyc >= stall_from && cyc < stall_from + 10) ? 1'b0 : ($urandom_range(0, 3) != 0);
                dn  = (cyc >= done_from) && (out_model > 0) && ($urandom_range(0, 2) == 0);
                cmd_ready = rdy;
                tile_done = dn;
                if (cmd_valid && rdy) begin
                    if (!got_first) begin
                        first_cmd = cmd_data;
                        got_first = 1;
                    end
                    if (exp_q.size() == 0) begin
                        extra++;
                    end else begin
                        e = exp_q.pop_front();
                        p = pe_q.pop_front();
                        chk($sformatf("cmd%0d", idx), cmd_data, e);
                        idx++;
                        if (p) bar_pend = 1;
                    end
                end
                out_model = out_model + ((cmd_valid && rdy) ? 1 : 0) - (dn ? 1 : 0);
                if (out_model > max_seen) max_seen = out_model;
                prev_wait = cmd_valid && !rdy;
                prev_data = cmd_data;
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("job_done_seen", 64'(done_seen), 64'(1));
        chk("first_valid_latency", 64'(first_lat), 64'(2));
        chk("cmds_left", 64'(exp_q.size()), 64'(0));
        chk("extra_cmds", 64'(extra), 64'(0));
        chk("hold_violations", 64'(hold_viol), 64'(0));
        chk("barrier_violations", 64'(barrier_viol), 64'(0));
        chk("outmax_violations", 64'(outmax_viol), 64'(0));
        chk("outstanding_at_done", 64'(out_model), 64'(0));
        cmd_ready = 1'b0;
        tile_done = 1'b0;
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(job_done), 64'(0));
        chk("ready_after_done", 64'(job_ready), 64'(1));
        chk("busy_after_done", 64'(job_busy), 64'(0));
    endtask

    initial begin
        logic [63:0] first;
        int          maxs;
        int          cnt;
        bit          seen;
        logic [63:0] t1_exp;

        rst = 1'b1; job_valid = 1'b0; cmd_ready = 1'b0; tile_done = 1'b0;
        job_base_a = '0; job_base_b = '0; job_base_c = '0; job_base_d = '0;
        job_m = '0; job_k = '0; job_n = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_job_ready", 64'(job_ready), 64'(1));
        chk("rst_cmd_valid", 64'(cmd_valid), 64'(0));
        chk("rst_cmd_data", cmd_data, 64'(0));
        chk("rst_job_busy", 64'(job_busy), 64'(0));
        chk("rst_job_done", 64'(job_done), 64'(0));
        chk("rst_job_err", 64'(job_err), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // single tile
        t1_exp = {10'd300, 10'd200, 10'd100, 10'd0, 8'd16, 8'd16, 8'd16};
        run_job(16, 16, 16, 0, 100, 200, 300, -100, 0, first, maxs);
        chk("single_tile_cmd", first, t1_exp);

        // ragged M and N
        run_job(20, 16, 33, 37, 512, 64, 700, -100, 0, first, maxs);

        // K accumulation with barriers
        run_job(16, 40, 16, 10, 20, 30, 40, -100, 0, first, maxs);

        // ready stall mid-job
        run_job(40, 16, 40, 5, 300, 600, 900, 8, 0, first, maxs);

        // completions withheld: window must fill to exactly MAX_OUT
        run_job(48, 16, 48, 0, 128, 256, 512, -100, 60, first, maxs);
        chk("max_outstanding", 64'(maxs), 64'(4));

        // D address wrap
        run_job(16, 16, 32, 0, 0, 0, 1020, -100, 0, first, maxs);

        // zero dimension rejected
        chk("err_ready_before", 64'(job_ready), 64'(1));
        job_m = 8'd5; job_k = 8'd5; job_n = 8'd0; job_valid = 1'b1;
        @(posedge clk); #1;
        job_valid = 1'b0;
        chk("err_pulse", 64'(job_err), 64'(1));
        chk("err_ready_after", 64'(job_ready), 64'(1));
        chk("err_not_busy", 64'(job_busy), 64'(0));
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 0) chk("err_pulse_ends", 64'(job_err), 64'(0));
            if (cmd_valid) cnt++;
        end
        chk("err_no_cmd", 64'(cnt), 64'(0));

        // reset in the middle of ISSUE
        job_base_a = 10'd0; job_base_b = 10'd0; job_base_c = 10'd0; job_base_d = 10'd0;
        job_m = 8'd48; job_k = 8'd48; job_n = 8'd48; job_valid = 1'b1;
        @(posedge clk); #1;
        job_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (cmd_valid) seen = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("rst_test_reached_issue", 64'(seen), 64'(1));
        cmd_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cmd_ready = 1'b0;
        @(posedge clk); #1;
        chk("midjob_rst_cmd_valid", 64'(cmd_valid), 64'(0));
        chk("midjob_rst_job_ready", 64'(job_ready), 64'(1));
        chk("midjob_rst_job_busy", 64'(job_busy), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // random jobs
        for (int j = 0; j < 10; j++) begin
            run_job($urandom_range(1, 70), $urandom_range(1, 70), $urandom_range(1, 70),
                    $urandom_range(0, 1023), $urandom_range(0, 1023),
                    $urandom_range(0, 1023), $urandom_range(0, 1023),
                    ($urandom_range(0, 1) != 0) ? $urandom_range(3, 30) : -100,
                    $urandom_range(0, 20), first, maxs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
